dcache_axi_master: RTL and testbench
====================================

# dcache_axi_master

- Converts the L1 data cache's miss/uncached/write-through request port into AXI4 master transactions on the system bus.
- Sits directly downstream of the data cache, in the CPU wrapper.
- Issues 2-beat 64-bit INCR read bursts for line fills, single-beat reads for uncacheable addresses, and single-beat writes.
- Returns each read beat to the cache with a valid pulse and holds a wait flag until the transaction completes.

## Interface

Parameters:
- AXI_ID, 4'd1: constant ARID/AWID driven on every transaction
- FILL_BEATS, 2: beats per line-fill burst (ARLEN = FILL_BEATS-1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- D_req  in  1  request; sampled only in IDLE
- D_addr  in  32  byte address; bursts are aligned by the block to 16 B
- D_write  in  1  1 = write, 0 = read
- D_in  in  64  write data, lane-positioned by the cache
- D_type  in  3  access type; D_type[1:0] gives AxSIZE for single-beat transfers
- D_strobe  in  8  byte write enables, active-low (0 = write byte)
- D_burst  in  1  read only: 1 = line fill, 0 = single beat
- D_out  out  64  read data (RDATA pass-through)
- D_valid  out  1  read beat valid
- D_wait  out  1  transaction in flight
- bus_err  out  1  sticky error flag
- AXI read address channel: ARID 4, ARADDR 32, ARLEN 4, ARSIZE 3, ARBURST 2, ARVALID out; ARREADY in
- AXI read data channel: RID 4, RDATA 64, RRESP 2, RLAST 1, RVALID in; RREADY out
- AXI write address channel: AWID 4, AWADDR 32, AWLEN 4, AWSIZE 3, AWBURST 2, AWVALID out; AWREADY in
- AXI write data channel: WDATA 64, WSTRB 8, WLAST 1, WVALID out; WREADY in
- AXI write response channel: BID 4, BRESP 2, BVALID in; BREADY out

## Operation

States: IDLE, AR, R, AWW, B.

IDLE:
- D_req=1 latches addr, write, data, strobe, type and burst into registers.
- Next state is AWW if write, else AR.

AR:
- ARVALID=1 until ARREADY.
- Burst: ARADDR = {addr[31:4], 4'b0}, ARLEN = FILL_BEATS-1, ARSIZE = 3'b011, ARBURST = INCR.
- Single: ARADDR = addr, ARLEN = 0, ARSIZE = {1'b0, type[1:0]}.
- Goes to R on handshake.

R:
- RREADY=1; D_valid = RVALID; D_out = RDATA.
- Beat counter (2 bits) increments on each RVALID.
- Exit to IDLE on the expected last beat.
- RLAST mismatch with the counter, or RRESP != OKAY, sets bus_err; the counter still governs exit.

AWW:
- AWVALID and WVALID rise together; each drops independently on its own handshake.
- Goes to B once both handshakes are done (same cycle or any order).
- WSTRB = ~strobe; WLAST = 1; AWLEN = 0; AWSIZE = {1'b0, type[1:0]}.

B:
- BREADY=1.
- BVALID returns to IDLE; BRESP != OKAY sets bus_err.

General rules:
- D_req is ignored outside IDLE.
- bus_err is cleared only by reset.

## Timing

Reset:
- State IDLE; every VALID/READY output, D_valid, D_wait and bus_err are 0.
- D_out follows RDATA; AXI address/data outputs are 0.
- Reset mid-transaction drops all valids asynchronously; the in-flight transaction is abandoned.

D_wait:
- 1 in the IDLE cycle where D_req=1, and in every non-IDLE cycle.
- Exception: 0 in the completion cycle, which is the last R beat or the B handshake.

Latency, request in cycle T:
- ARVALID/AWVALID are first high in T+1.
- Zero-wait slave: read fill returns beats at T+2 and T+3, D_wait low at T+3; write gives B at T+2, D_wait low at T+2.
- Back-to-back: a new request is accepted in the first IDLE cycle after completion, i.e. one cycle after D_wait falls.
- The 128-bit line is reassembled by the cache, not here.

## Structure

- Shared package (same one that holds the AXI/cache width macros) gains:
  - state enum
  - AXI burst/resp constants: INCR = 2'b01, OKAY = 2'b00
  - FILL_SIZE = 3'b011
- Single module; no sub-module.

## Test plan

- Fill read, addr 0x0000_1234, burst=1, zero-wait slave -> ARADDR 0x0000_1230, ARLEN 1, ARSIZE 3; D_valid at T+2 and T+3 with the slave data; D_wait low at T+3.
- Uncached read, addr 0x1000_0008, burst=0, type word, ARREADY delayed 3 cycles -> ARVALID held 4 cycles, ARLEN 0, ARSIZE 2; one D_valid.
- Write, addr 0x0000_2004, strobe 8'h0F, data 0xDEADBEEF_00000000; WREADY 2 cycles before AWREADY -> WSTRB 8'hF0, enters B only after both handshakes; D_wait falls on BVALID.
- Error: RRESP=SLVERR on beat 2, then BRESP=DECERR -> bus_err set and held across later OKAY transactions until rst.
- Reset asserted mid-R after beat 1 -> all valids 0 asynchronously; the next D_req after release starts a clean AR.
- D_req held high through a fill -> exactly one AR issued; a second AR appears one cycle after completion.

Source files
------------

// File: rtl/dcache_axi_master_pkg.sv
// Shared bus/cache definitions for the data-cache AXI4 master: widths,
// AXI encodings and the bridge state machine encoding.
package dcache_axi_master_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] INCR      = 2'b01;
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [2:0] FILL_SIZE = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } state_t;

    // Line fills always start on a 16-byte boundary.
    function automatic logic [AXI_ADDR_W-1:0] line_align(input logic [AXI_ADDR_W-1:0] addr);
        return {addr[AXI_ADDR_W-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/dcache_axi_master_if.sv
// AXI4 system-bus channels seen by the data-cache master.
interface dcache_axi_master_if;
    import dcache_axi_master_pkg::*;

    logic [AXI_ID_W-1:0]   ARID;
    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [AXI_ID_W-1:0]   RID;
    logic [AXI_DATA_W-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    logic [AXI_ID_W-1:0]   AWID;
    logic [AXI_ADDR_W-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [AXI_DATA_W-1:0] WDATA;
    logic [AXI_STRB_W-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [AXI_ID_W-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY
    );

endinterface

// File: rtl/dcache_axi_master.sv
// Turns L1 data-cache miss / uncached / write-through requests into AXI4
// transactions: burst line fills, single-beat reads and single-beat writes.
module dcache_axi_master
    import dcache_axi_master_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         FILL_BEATS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  D_req,
    input  logic [AXI_ADDR_W-1:0] D_addr,
    input  logic                  D_write,
    input  logic [AXI_DATA_W-1:0] D_in,
    input  logic [2:0]            D_type,
    input  logic [AXI_STRB_W-1:0] D_strobe,
    input  logic                  D_burst,
    output logic [AXI_DATA_W-1:0] D_out,
    output logic                  D_valid,
    output logic                  D_wait,
    output logic                  bus_err,
    dcache_axi_master_if.master   axi
);

    localparam logic [1:0] LAST_BEAT = 2'(FILL_BEATS - 1);

    state_t                state_reg;
    logic                  burst_reg;
    logic [1:0]            beat_reg;
    logic                  err_reg;
    logic                  arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
    logic [AXI_ADDR_W-1:0] araddr_reg, awaddr_reg;
    logic [3:0]            arlen_reg;
    logic [2:0]            arsize_reg, awsize_reg;
    logic [1:0]            arburst_reg, awburst_reg;
    logic [AXI_DATA_W-1:0] wdata_reg;
    logic [AXI_STRB_W-1:0] wstrb_reg;
    logic                  wlast_reg;

    logic r_last_beat, aw_done, w_done, done;
    logic unused_bits;

    // The beat counter, not RLAST, decides when the read is over.
    assign r_last_beat = burst_reg ? (beat_reg == LAST_BEAT) : (beat_reg == 2'd0);
    assign aw_done     = !awvalid_reg || axi.AWREADY;
    assign w_done      = !wvalid_reg  || axi.WREADY;
    assign done        = ((state_reg == ST_R) && axi.RVALID && r_last_beat) ||
                         ((state_reg == ST_B) && axi.BVALID);

    assign D_out   = axi.RDATA;
    assign D_valid = rready_reg && axi.RVALID;
    assign D_wait  = (state_reg == ST_IDLE) ? D_req : !done;
    assign bus_err = err_reg;

    assign axi.ARID    = AXI_ID;
    assign axi.ARADDR  = araddr_reg;
    assign axi.ARLEN   = arlen_reg;
    assign axi.ARSIZE  = arsize_reg;
    assign axi.ARBURST = arburst_reg;
    assign axi.ARVALID = arvalid_reg;
    assign axi.RREADY  = rready_reg;
    assign axi.AWID    = AXI_ID;
    assign axi.AWADDR  = awaddr_reg;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = awsize_reg;
    assign axi.AWBURST = awburst_reg;
    assign axi.AWVALID = awvalid_reg;
    assign axi.WDATA   = wdata_reg;
    assign axi.WSTRB   = wstrb_reg;
    assign axi.WLAST   = wlast_reg;
    assign axi.WVALID  = wvalid_reg;
    assign axi.BREADY  = bready_reg;

    assign unused_bits = &{1'b0, D_type[2], axi.RID, axi.BID};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            burst_reg   <= 1'b0;
            beat_reg    <= 2'd0;
            err_reg     <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            araddr_reg  <= '0;
            awaddr_reg  <= '0;
            arlen_reg   <= 4'd0;
            arsize_reg  <= 3'd0;
            awsize_reg  <= 3'd0;
            arburst_reg <= 2'd0;
            awburst_reg <= 2'd0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            wlast_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (D_req) begin
                        burst_reg <= D_burst && !D_write;
                        if (D_write) begin
                            awaddr_reg  <= D_addr;
                            awsize_reg  <= {1'b0, D_type[1:0]};
                            awburst_reg <= INCR;
                            wdata_reg   <= D_in;
                            wstrb_reg   <= ~D_strobe;
                            wlast_reg   <= 1'b1;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_AWW;
                        end else begin
                            araddr_reg  <= D_burst ? line_align(D_addr) : D_addr;
                            arlen_reg   <= D_burst ? 4'(FILL_BEATS - 1) : 4'd0;
                            arsize_reg  <= D_burst ? FILL_SIZE : {1'b0, D_type[1:0]};
                            arburst_reg <= INCR;
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (axi.ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        beat_reg    <= 2'd0;
                        state_reg   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi.RVALID) begin
                        beat_reg <= beat_reg + 2'd1;
                        if ((axi.RLAST != r_last_beat) || (axi.RRESP != OKAY))
                            err_reg <= 1'b1;
                        if (r_last_beat) begin
                            rready_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end
                    end
                end
                ST_AWW: begin
                    if (awvalid_reg && axi.AWREADY) awvalid_reg <= 1'b0;
                    if (wvalid_reg && axi.WREADY)   wvalid_reg  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi.BVALID) begin
                        if (axi.BRESP != OKAY) err_reg <= 1'b1;
                        bready_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Directed bench for dcache_axi_master: a hand-driven AXI slave with
// hand-computed expectations for fills, uncached reads, writes and errors.
module tb_dcache_axi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        D_req = 1'b0;
    logic [31:0] D_addr = '0;
    logic        D_write = 1'b0;
    logic [63:0] D_in = '0;
    logic [2:0]  D_type = '0;
    logic [7:0]  D_strobe = 8'hFF;
    logic        D_burst = 1'b0;
    logic [63:0] D_out;
    logic        D_valid;
    logic        D_wait;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    dcache_axi_master_if axi();

    dcache_axi_master #(.AXI_ID(4'd1), .FILL_BEATS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .D_req    (D_req),
        .D_addr   (D_addr),
        .D_write  (D_write),
        .D_in     (D_in),
        .D_type   (D_type),
        .D_strobe (D_strobe),
        .D_burst  (D_burst),
        .D_out    (D_out),
        .D_valid  (D_valid),
        .D_wait   (D_wait),
        .bus_err  (bus_err),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic slave_defaults();
        axi.ARREADY = 1'b1;
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RRESP   = 2'b00;
        axi.RID     = 4'd1;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        axi.BID     = 4'd1;
    endtask

    task automatic run_fill(input logic [31:0] addr, input logic [1:0] resp2, input logic rlast1);
        cyc(); D_req = 1'b1; D_addr = addr; D_write = 1'b0; D_burst = 1'b1; D_type = 3'b011;
        cyc(); D_req = 1'b0;
        cyc(); axi.RVALID = 1'b1; axi.RLAST = rlast1; axi.RRESP = 2'b00; axi.RDATA = 64'h11;
        cyc(); axi.RLAST = 1'b1; axi.RRESP = resp2; axi.RDATA = 64'h22;
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RRESP = 2'b00;
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [1:0] bresp);
        cyc(); D_req = 1'b1; D_addr = addr; D_write = 1'b1; D_in = 64'h55; D_strobe = 8'h00; D_type = 3'b011;
        cyc(); D_req = 1'b0; D_write = 1'b0;
        cyc(); axi.BVALID = 1'b1; axi.BRESP = bresp;
        cyc(); axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    endtask

    task automatic test_reset();
        slave_defaults();
        axi.RDATA = 64'h0123_4567_89AB_CDEF;
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_valids: got %b want 00000",
                     {axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY});
        end
        vectors++;
        if ({D_valid, D_wait, bus_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000", {D_valid, D_wait, bus_err});
        end
        vectors++;
        if (D_out !== 64'h0123_4567_89AB_CDEF) begin
            miscompares++;
            $display("FAIL reset_dout: got %h want 0123456789abcdef", D_out);
        end
        vectors++;
        if ({axi.ARADDR, axi.AWADDR, axi.WDATA, axi.WSTRB} !== '0) begin
            miscompares++;
            $display("FAIL reset_addr_data: got %h %h %h %h want zeros",
                     axi.ARADDR, axi.AWADDR, axi.WDATA, axi.WSTRB);
        end
        cyc(); cyc(); rst = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_fill();
        cyc(); D_req = 1'b1; D_addr = 32'h0000_1234; D_write = 1'b0; D_burst = 1'b1; D_type = 3'b011;
        #1;
        vectors++;
        if ({D_wait, axi.ARVALID} !== 2'b10) begin
            miscompares++;
            $display("FAIL fill_req_cycle: got wait,arvalid=%b want 10", {D_wait, axi.ARVALID});
        end
        cyc(); D_req = 1'b0; #1;
        vectors++;
        if ({axi.ARVALID, axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST} !==
            {1'b1, 4'd1, 32'h0000_1230, 4'd1, 3'd3, 2'b01}) begin
            miscompares++;
            $display("FAIL fill_ar: got v=%b id=%h addr=%h len=%0d size=%0d burst=%b want v=1 id=1 addr=00001230 len=1 size=3 burst=01",
                     axi.ARVALID, axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST);
        end
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b0; axi.RDATA = 64'hAAAA_0000_1111_0001; #1;
        vectors++;
        if ({axi.RREADY, D_valid, D_wait, D_out} !== {3'b111, 64'hAAAA_0000_1111_0001}) begin
            miscompares++;
            $display("FAIL fill_beat1: got rready,valid,wait=%b data=%h want 111 aaaa000011110001",
                     {axi.RREADY, D_valid, D_wait}, D_out);
        end
        cyc(); axi.RLAST = 1'b1; axi.RDATA = 64'hBBBB_0000_2222_0002; #1;
        vectors++;
        if ({D_valid, D_wait, D_out} !== {2'b10, 64'hBBBB_0000_2222_0002}) begin
            miscompares++;
            $display("FAIL fill_beat2: got valid,wait=%b data=%h want 10 bbbb000022220002",
                     {D_valid, D_wait}, D_out);
        end
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0; #1;
        vectors++;
        if ({axi.RREADY, axi.ARVALID, D_wait, bus_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL fill_done: got rready,arvalid,wait,err=%b want 0000",
                     {axi.RREADY, axi.ARVALID, D_wait, bus_err});
        end
        $display("fill read 0x00001234: two beats returned");
    endtask

    task automatic test_uncached();
        cyc(); D_req = 1'b1; D_addr = 32'h1000_0008; D_write = 1'b0; D_burst = 1'b0; D_type = 3'b010;
        axi.ARREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); D_req = 1'b0; axi.ARREADY = (k == 3); #1;
            vectors++;
            if ({axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.ARSIZE} !== {1'b1, 32'h1000_0008, 4'd0, 3'd2}) begin
                miscompares++;
                $display("FAIL uc_ar_hold%0d: got v=%b addr=%h len=%0d size=%0d want v=1 addr=10000008 len=0 size=2",
                         k, axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.ARSIZE);
            end
        end
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b1; axi.RDATA = 64'h0000_0000_CAFE_F00D; #1;
        vectors++;
        if ({axi.ARVALID, axi.RREADY, D_valid, D_wait, D_out} !== {4'b0110, 64'h0000_0000_CAFE_F00D}) begin
            miscompares++;
            $display("FAIL uc_beat: got arv,rready,valid,wait=%b data=%h want 0110 00000000cafef00d",
                     {axi.ARVALID, axi.RREADY, D_valid, D_wait}, D_out);
        end
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0; #1;
        vectors++;
        if ({axi.RREADY, D_valid, D_wait} !== 3'b000) begin
            miscompares++;
            $display("FAIL uc_done: got rready,valid,wait=%b want 000", {axi.RREADY, D_valid, D_wait});
        end
        $display("uncached read 0x10000008: one beat after 3-cycle ARREADY stall");
    endtask

    task automatic test_write();
        cyc(); D_req = 1'b1; D_addr = 32'h0000_2004; D_write = 1'b1; D_type = 3'b010;
        D_in = 64'hDEAD_BEEF_0000_0000; D_strobe = 8'h0F;
        cyc(); D_req = 1'b0; D_write = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b1; #1;
        vectors++;
        if ({axi.AWVALID, axi.WVALID, axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST} !==
            {2'b11, 4'd1, 32'h0000_2004, 4'd0, 3'd2, 2'b01}) begin
            miscompares++;
            $display("FAIL wr_aw: got awv,wv=%b id=%h addr=%h len=%0d size=%0d burst=%b want 11 1 00002004 0 2 01",
                     {axi.AWVALID, axi.WVALID}, axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST);
        end
        vectors++;
        if ({axi.WDATA, axi.WSTRB, axi.WLAST} !== {64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_w: got data=%h strb=%h last=%b want deadbeef00000000 f0 1",
                     axi.WDATA, axi.WSTRB, axi.WLAST);
        end
        cyc(); axi.WREADY = 1'b0; #1;
        vectors++;
        if ({axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== 4'b1001) begin
            miscompares++;
            $display("FAIL wr_w_done: got awv,wv,bready,wait=%b want 1001",
                     {axi.AWVALID, axi.WVALID, axi.BREADY, D_wait});
        end
        cyc(); axi.AWREADY = 1'b1; #1;
        vectors++;
        if ({axi.AWVALID, axi.WVALID, axi.BREADY, D_wait} !== 4'b1001) begin
            miscompares++;
            $display("FAIL wr_aw_late: got awv,wv,bready,wait=%b want 1001",
                     {axi.AWVALID, axi.WVALID, axi.BREADY, D_wait});
        end
        cyc(); axi.WREADY = 1'b1; axi.BVALID = 1'b1; axi.BRESP = 2'b00; #1;
        vectors++;
        if ({axi.AWVALID, axi.BREADY, D_wait} !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_b: got awv,bready,wait=%b want 010", {axi.AWVALID, axi.BREADY, D_wait});
        end
        cyc(); axi.BVALID = 1'b0; #1;
        vectors++;
        if ({axi.BREADY, D_wait, bus_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_done: got bready,wait,err=%b want 000", {axi.BREADY, D_wait, bus_err});
        end
        $display("write 0x00002004: WSTRB f0, B after late AWREADY");
    endtask

    task automatic test_errors();
        run_fill(32'h0000_0040, 2'b10, 1'b0); #1;
        vectors++;
        if (bus_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_rresp: got bus_err=%b want 1", bus_err);
        end
        run_write(32'h0000_0048, 2'b00); #1;
        vectors++;
        if (bus_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got bus_err=%b want 1", bus_err);
        end
        rst = 1'b1; #1;
        vectors++;
        if (bus_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got bus_err=%b want 0", bus_err);
        end
        cyc(); rst = 1'b0;
        run_write(32'h0000_0050, 2'b11); #1;
        vectors++;
        if (bus_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_bresp: got bus_err=%b want 1", bus_err);
        end
        rst = 1'b1;
        cyc(); rst = 1'b0;
        run_fill(32'h0000_0060, 2'b00, 1'b1); #1;
        vectors++;
        if ({bus_err, axi.RREADY, D_wait} !== 3'b100) begin
            miscompares++;
            $display("FAIL err_rlast: got err,rready,wait=%b want 100", {bus_err, axi.RREADY, D_wait});
        end
        rst = 1'b1;
        cyc(); rst = 1'b0;
        $display("errors: SLVERR, DECERR and early RLAST each flag bus_err");
    endtask

    task automatic test_reset_mid();
        cyc(); D_req = 1'b1; D_addr = 32'h0000_0080; D_write = 1'b0; D_burst = 1'b1; D_type = 3'b011;
        cyc(); D_req = 1'b0;
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b0; axi.RDATA = 64'h77; #1;
        vectors++;
        if (D_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_beat1: got D_valid=%b want 1", D_valid);
        end
        #1 rst = 1'b1; #1;
        vectors++;
        if ({axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY, D_valid, D_wait} !== 7'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got %b want 0000000",
                     {axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY, D_valid, D_wait});
        end
        cyc(); rst = 1'b0; axi.RVALID = 1'b0;
        cyc(); D_req = 1'b1; D_addr = 32'h1000_0010; D_burst = 1'b0; D_type = 3'b010;
        cyc(); D_req = 1'b0; #1;
        vectors++;
        if ({axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.RREADY} !== {1'b1, 32'h1000_0010, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midrst_new_ar: got v=%b addr=%h len=%0d rready=%b want 1 10000010 0 0",
                     axi.ARVALID, axi.ARADDR, axi.ARLEN, axi.RREADY);
        end
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b1; #1;
        vectors++;
        if ({D_valid, D_wait} !== 2'b10) begin
            miscompares++;
            $display("FAIL midrst_new_r: got valid,wait=%b want 10", {D_valid, D_wait});
        end
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        $display("reset mid-fill: abandoned, clean single read afterwards");
    endtask

    task automatic test_back_to_back();
        cyc(); D_req = 1'b1; D_addr = 32'h0000_0100; D_write = 1'b0; D_burst = 1'b1; D_type = 3'b011;
        cyc(); #1;
        vectors++;
        if (axi.ARVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ar1: got ARVALID=%b want 1", axi.ARVALID);
        end
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b0; #1;
        vectors++;
        if ({axi.ARVALID, D_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_beat1: got arvalid,valid=%b want 01", {axi.ARVALID, D_valid});
        end
        cyc(); axi.RLAST = 1'b1; #1;
        vectors++;
        if ({axi.ARVALID, D_valid, D_wait} !== 3'b010) begin
            miscompares++;
            $display("FAIL b2b_beat2: got arvalid,valid,wait=%b want 010", {axi.ARVALID, D_valid, D_wait});
        end
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0; #1;
        vectors++;
        if ({axi.ARVALID, D_wait} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_accept: got arvalid,wait=%b want 01", {axi.ARVALID, D_wait});
        end
        cyc(); D_req = 1'b0; #1;
        vectors++;
        if ({axi.ARVALID, axi.ARADDR} !== {1'b1, 32'h0000_0100}) begin
            miscompares++;
            $display("FAIL b2b_ar2: got v=%b addr=%h want 1 00000100", axi.ARVALID, axi.ARADDR);
        end
        cyc(); axi.RVALID = 1'b1; axi.RLAST = 1'b0;
        cyc(); axi.RLAST = 1'b1; #1;
        vectors++;
        if (D_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done2: got D_wait=%b want 0", D_wait);
        end
        cyc(); axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        $display("back-to-back fills: second AR after first completes");
    endtask

    initial begin
        axi.RDATA = '0;
        test_reset();
        test_fill();
        test_uncached();
        test_write();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
